// File: rtl/sipo_packer.sv
// 2-bit symbol to 16-bit word packer with a one-word holding register toward a FIFO.
// Optional partial-word flush is built in when SIPO_FLUSH_EN is defined.
module sipo_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  data_serial_i,
    input  logic        valid_serial_i,
    output logic        ready_serial_o,
    output logic [15:0] fifo_data_o,
    output logic        fifo_wr_en_o,
`ifdef SIPO_FLUSH_EN
    input  logic        flush_i,
    output logic        flush_done_o,
`endif
    input  logic        fifo_full_i
);

    typedef enum logic [1:0] {COLLECT, HOLD, STALL} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  cnt;
    logic [2:0]  cnt_nxt;
    logic [15:0] sr;
    logic [15:0] sr_nxt;
    logic [3:0]  cnt_eff;
    logic        pending;
    logic        pend_nxt;
    logic        accept;
    logic        complete;
    logic        flush_load;
    logic        flush_pulse;
    logic [15:0] pad_word;

    assign pending        = (state != COLLECT);
    assign fifo_wr_en_o   = pending && !fifo_full_i;
    assign ready_serial_o = !((state == STALL) && !fifo_wr_en_o);
    assign accept         = valid_serial_i && ready_serial_o;

    always_comb begin
        sr_nxt   = accept ? {sr[13:0], data_serial_i} : sr;
        cnt_eff  = {1'b0, cnt} + {3'b000, accept};
        complete = accept && (cnt == 3'd7);
        // Partial word includes any symbol accepted on this edge, then left-aligned.
        pad_word    = sr_nxt << (5'd16 - {cnt_eff, 1'b0});
        flush_load  = 1'b0;
        flush_pulse = 1'b0;
`ifdef SIPO_FLUSH_EN
        if (flush_i && !flush_done_o && (!pending || fifo_wr_en_o)) begin
            flush_pulse = 1'b1;
            flush_load  = !complete && (cnt_eff != 4'd0);
        end
`endif
        pend_nxt = complete || flush_load || (pending && !fifo_wr_en_o);
        cnt_nxt  = (complete || flush_load) ? 3'd0 : cnt_eff[2:0];
        if (!pend_nxt)
            state_nxt = COLLECT;
        else if (cnt_nxt == 3'd7)
            state_nxt = STALL;
        else
            state_nxt = HOLD;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= COLLECT;
            cnt         <= '0;
            sr          <= '0;
            fifo_data_o <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            sr    <= flush_load ? '0 : sr_nxt;
            if (complete)
                fifo_data_o <= sr_nxt;
            else if (flush_load)
                fifo_data_o <= pad_word;
        end
    end

`ifdef SIPO_FLUSH_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            flush_done_o <= 1'b0;
        else
            flush_done_o <= flush_pulse;
    end
`else
    logic unused_flush;
    assign unused_flush = flush_pulse;
`endif

endmodule

// File: tb/tb_sipo_packer.sv
// Directed self-checking bench for sipo_packer; flush steps run when SIPO_FLUSH_EN is defined.
module tb_sipo_packer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  data_serial_i;
    logic        valid_serial_i;
    logic        ready_serial_o;
    logic [15:0] fifo_data_o;
    logic        fifo_wr_en_o;
    logic        fifo_full_i;
`ifdef SIPO_FLUSH_EN
    logic        flush_i;
    logic        flush_done_o;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sipo_packer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .data_serial_i  (data_serial_i),
        .valid_serial_i (valid_serial_i),
        .ready_serial_o (ready_serial_o),
        .fifo_data_o    (fifo_data_o),
        .fifo_wr_en_o   (fifo_wr_en_o),
`ifdef SIPO_FLUSH_EN
        .flush_i        (flush_i),
        .flush_done_o   (flush_done_o),
`endif
        .fifo_full_i    (fifo_full_i)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n          = 1'b0;
        data_serial_i  = 2'b00;
        valid_serial_i = 1'b0;
        fifo_full_i    = 1'b0;
`ifdef SIPO_FLUSH_EN
        flush_i        = 1'b0;
`endif
        step();
        step();
        chk("rst_ready", {15'd0, ready_serial_o}, 16'd1);
        chk("rst_wr_en", {15'd0, fifo_wr_en_o}, 16'd0);
        chk("rst_data", fifo_data_o, 16'h0000);
        rst_n = 1'b1;

        // Eight 2'b10 symbols back to back -> one AAAA write right after the 8th edge
        for (int i = 0; i < 8; i++) begin
            valid_serial_i = 1'b1;
            data_serial_i  = 2'b10;
            step();
            chk("aaaa_wr_timing", {15'd0, fifo_wr_en_o}, (i == 7) ? 16'd1 : 16'd0);
        end
        valid_serial_i = 1'b0;
        chk("aaaa_data", fifo_data_o, 16'hAAAA);
        step();
        chk("aaaa_single_pulse", {15'd0, fifo_wr_en_o}, 16'd0);

        // Sixteen 2'b01 symbols -> two 5555 writes eight cycles apart, ready never drops
        for (int i = 0; i < 16; i++) begin
            valid_serial_i = 1'b1;
            data_serial_i  = 2'b01;
            #1;
            chk("5555_ready", {15'd0, ready_serial_o}, 16'd1);
            step();
            chk("5555_wr_timing", {15'd0, fifo_wr_en_o}, (i == 7 || i == 15) ? 16'd1 : 16'd0);
            if (i == 7 || i == 15)
                chk("5555_data", fifo_data_o, 16'h5555);
        end
        valid_serial_i = 1'b0;
        step();
        chk("5555_idle", {15'd0, fifo_wr_en_o}, 16'd0);

        // FFFF held while FIFO full; ready drops after 7 more symbols
        fifo_full_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            valid_serial_i = 1'b1;
            data_serial_i  = 2'b11;
            step();
        end
        chk("full_no_write", {15'd0, fifo_wr_en_o}, 16'd0);
        for (int i = 0; i < 20; i++) begin
            data_serial_i = 2'b00;
            chk("full_hold_data", fifo_data_o, 16'hFFFF);
            chk("full_ready", {15'd0, ready_serial_o}, (i < 7) ? 16'd1 : 16'd0);
            chk("full_wr_en", {15'd0, fifo_wr_en_o}, 16'd0);
            step();
        end
        fifo_full_i = 1'b0;
        #1;
        chk("drain_wr_en", {15'd0, fifo_wr_en_o}, 16'd1);
        chk("drain_data", fifo_data_o, 16'hFFFF);
        chk("drain_ready", {15'd0, ready_serial_o}, 16'd1);
        step();
        valid_serial_i = 1'b0;
        chk("simul_wr_en", {15'd0, fifo_wr_en_o}, 16'd1);
        chk("simul_data", fifo_data_o, 16'h0000);
        step();
        chk("simul_done", {15'd0, fifo_wr_en_o}, 16'd0);
        chk("simul_ready", {15'd0, ready_serial_o}, 16'd1);

        // Gaps in valid must not shift in the garbage on data_serial_i
        for (int i = 0; i < 11; i++) begin
            valid_serial_i = (i < 4 || i >= 7);
            data_serial_i  = (i < 4 || i >= 7) ? 2'b10 : 2'b11;
            step();
            chk("gap_wr_timing", {15'd0, fifo_wr_en_o}, (i == 10) ? 16'd1 : 16'd0);
        end
        valid_serial_i = 1'b0;
        chk("gap_data", fifo_data_o, 16'hAAAA);
        step();

        // Reset mid-word discards the partial symbols
        for (int i = 0; i < 5; i++) begin
            valid_serial_i = 1'b1;
            data_serial_i  = 2'b11;
            step();
        end
        valid_serial_i = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("async_rst_data", fifo_data_o, 16'h0000);
        chk("async_rst_ready", {15'd0, ready_serial_o}, 16'd1);
        step();
        step();
        chk("rst_hold_wr_en", {15'd0, fifo_wr_en_o}, 16'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            valid_serial_i = 1'b1;
            data_serial_i  = 2'b01;
            step();
            chk("post_rst_wr", {15'd0, fifo_wr_en_o}, (i == 7) ? 16'd1 : 16'd0);
        end
        valid_serial_i = 1'b0;
        chk("post_rst_data", fifo_data_o, 16'h5555);
        step();
        chk("post_rst_single", {15'd0, fifo_wr_en_o}, 16'd0);

`ifdef SIPO_FLUSH_EN
        for (int i = 0; i < 3; i++) begin
            valid_serial_i = 1'b1;
            data_serial_i  = 2'b11;
            step();
        end
        valid_serial_i = 1'b0;
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        chk("flush_done", {15'd0, flush_done_o}, 16'd1);
        chk("flush_wr_en", {15'd0, fifo_wr_en_o}, 16'd1);
        chk("flush_data", fifo_data_o, 16'hFC00);
        step();
        chk("flush_done_single", {15'd0, flush_done_o}, 16'd0);
        chk("flush_wr_single", {15'd0, fifo_wr_en_o}, 16'd0);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        chk("flush_empty_done", {15'd0, flush_done_o}, 16'd1);
        chk("flush_empty_no_wr", {15'd0, fifo_wr_en_o}, 16'd0);
        step();
        chk("flush_empty_single", {15'd0, flush_done_o}, 16'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
